// File: rtl/lc3b_wb_stage.sv
// LC-3b write-back stage: result latch, LDB byte formatting, register-file write port,
// operand bypass, condition codes, per-register pending-write scoreboard and retire counter.
module lc3b_wb_stage #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [2:0]  mem_dr,
  input  logic [15:0] mem_result,
  input  logic        mem_ld_reg,
  input  logic        mem_ld_cc,
  input  logic        mem_byte,
  input  logic        mem_addr0,
  input  logic        issue_valid,
  input  logic        issue_ld_reg,
  input  logic [2:0]  issue_dr,
  input  logic [2:0]  rd_sr1,
  input  logic [2:0]  rd_sr2,
  input  logic [15:0] rf_sr1_out,
  input  logic [15:0] rf_sr2_out,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_data,
  output logic [15:0] sr1_val,
  output logic [15:0] sr2_val,
  output logic [2:0]  nzp,
  output logic [7:0]  busy,
  output logic        sb_ovf,
  output logic [15:0] retired
);

  typedef struct packed {
    logic        valid;
    logic [2:0]  dr;
    logic [15:0] result;
    logic        ld_reg;
    logic        ld_cc;
    logic        byte_ld;
    logic        addr0;
  } wb_latch_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_latch_t        wb;
  logic [CNT_W-1:0] cnt [8];
  logic [7:0]       byte_sel;
  logic [7:0]       inc;
  logic [7:0]       dec;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb <= '0;
    end else begin
      wb <= '{valid: mem_valid, dr: mem_dr, result: mem_result, ld_reg: mem_ld_reg,
              ld_cc: mem_ld_cc, byte_ld: mem_byte, addr0: mem_addr0};
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_sel = wb.addr0 ? wb.result[15:8] : wb.result[7:0];
    rf_data  = wb.result;
    if (wb.byte_ld) rf_data = {{8{byte_sel[7]}}, byte_sel};
  end

  assign rf_we   = wb.valid & wb.ld_reg;
  assign rf_dr   = wb.dr;
  assign sr1_val = (rf_we && rd_sr1 == rf_dr) ? rf_data : rf_sr1_out;
  assign sr2_val = (rf_we && rd_sr2 == rf_dr) ? rf_data : rf_sr2_out;

  assign inc = (issue_valid && issue_ld_reg) ? (8'b1 << issue_dr) : 8'b0;
  assign dec = rf_we ? (8'b1 << rf_dr) : 8'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp     <= 3'b010;
      retired <= '0;
    end else begin
      if (wb.valid && wb.ld_cc) begin
        if (rf_data[15])         nzp <= 3'b100;
        else if (rf_data == '0)  nzp <= 3'b010;
        else                     nzp <= 3'b001;
      end
      if (wb.valid) retired <= retired + 16'd1;
    end
  end

  // NOTE: the counter array is reset explicitly because busy must read clear straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      sb_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        // Matching increment and decrement cancel; saturating either way flags overflow.
        if (inc[i] && !dec[i]) begin
          if (cnt[i] == CNT_MAX) sb_ovf <= 1'b1;
          else                   cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i]) begin
          if (cnt[i] == '0) sb_ovf <= 1'b1;
          else              cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 8; i++) busy[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_lc3b_wb_stage.sv
// Self-checking bench for lc3b_wb_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of pending writes, condition codes and retire count.
module tb_lc3b_wb_stage;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid, mem_ld_reg, mem_ld_cc, mem_byte, mem_addr0;
  logic [2:0]  mem_dr;
  logic [15:0] mem_result;
  logic        issue_valid, issue_ld_reg;
  logic [2:0]  issue_dr, rd_sr1, rd_sr2;
  logic [15:0] rf_sr1_out, rf_sr2_out;
  logic        rf_we, sb_ovf;
  logic [2:0]  rf_dr, nzp;
  logic [15:0] rf_data, sr1_val, sr2_val, retired;
  logic [7:0]  busy;

  int passed = 0;
  int total  = 0;

  // Behavioural model: pending-write counts per register, sticky error, flags, retire count
  int          m_cnt [8];
  bit          m_ovf;
  logic [2:0]  m_nzp;
  int          m_retired;
  bit          l_valid, l_ld_reg, l_ld_cc, l_byte, l_addr0;
  logic [2:0]  l_dr;
  logic [15:0] l_raw;

  lc3b_wb_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_result(mem_result),
    .mem_ld_reg(mem_ld_reg), .mem_ld_cc(mem_ld_cc), .mem_byte(mem_byte), .mem_addr0(mem_addr0),
    .issue_valid(issue_valid), .issue_ld_reg(issue_ld_reg), .issue_dr(issue_dr),
    .rd_sr1(rd_sr1), .rd_sr2(rd_sr2), .rf_sr1_out(rf_sr1_out), .rf_sr2_out(rf_sr2_out),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data), .sr1_val(sr1_val), .sr2_val(sr2_val),
    .nzp(nzp), .busy(busy), .sb_ovf(sb_ovf), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] fmt(logic [15:0] raw, bit byte_ld, bit a0);
    int b;
    if (!byte_ld) return raw;
    b = a0 ? int'(raw) / 256 : int'(raw) % 256;
    if (b >= 128) b -= 256;
    return 16'(b);
  endfunction

  function automatic logic [7:0] exp_busy();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  function automatic bit exp_we();
    return l_valid && l_ld_reg;
  endfunction

  function automatic logic [15:0] exp_data();
    return fmt(l_raw, l_byte, l_addr0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_ovf = 0; m_nzp = 3'b010; m_retired = 0;
    l_valid = 0; l_ld_reg = 0; l_ld_cc = 0; l_byte = 0; l_addr0 = 0; l_dr = '0; l_raw = '0;
  endtask

  task automatic set_idle();
    mem_valid = 0; mem_dr = '0; mem_result = '0; mem_ld_reg = 0; mem_ld_cc = 0;
    mem_byte = 0; mem_addr0 = 0; issue_valid = 0; issue_ld_reg = 0; issue_dr = '0;
    rd_sr1 = '0; rd_sr2 = '0; rf_sr1_out = '0; rf_sr2_out = '0;
  endtask

  task automatic drive_mem(logic [2:0] dr, logic [15:0] raw, bit ld_reg, bit ld_cc, bit b, bit a0);
    mem_valid = 1; mem_dr = dr; mem_result = raw; mem_ld_reg = ld_reg;
    mem_ld_cc = ld_cc; mem_byte = b; mem_addr0 = a0;
  endtask

  // Step one clock: the model applies the edge with the inputs that were held across it.
  task automatic advance();
    bit we;
    logic [15:0] d;
    @(posedge clk);
    we = exp_we();
    d  = exp_data();
    if (l_valid && l_ld_cc) m_nzp = d[15] ? 3'b100 : (d == 0) ? 3'b010 : 3'b001;
    if (l_valid) m_retired = (m_retired + 1) % 65536;
    for (int i = 0; i < 8; i++) begin
      bit up, dn;
      up = issue_valid && issue_ld_reg && issue_dr == i;
      dn = we && l_dr == i;
      if (up && !dn) begin
        if (m_cnt[i] == CMAX) m_ovf = 1; else m_cnt[i]++;
      end else if (dn && !up) begin
        if (m_cnt[i] == 0) m_ovf = 1; else m_cnt[i]--;
      end
    end
    l_valid = mem_valid; l_ld_reg = mem_ld_reg; l_ld_cc = mem_ld_cc; l_byte = mem_byte;
    l_addr0 = mem_addr0; l_dr = mem_dr; l_raw = mem_result;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) advance();
    total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", rf_we); else passed++;
    total++; if (nzp !== 3'b010) $display("FAIL reset_nzp: got %b want 010", nzp); else passed++;
    total++; if (busy !== 8'h00) $display("FAIL reset_busy: got %h want 00", busy); else passed++;
    total++; if (retired !== 16'd0) $display("FAIL reset_retired: got %0d want 0", retired); else passed++;
    total++; if (sb_ovf !== 1'b0) $display("FAIL reset_sb_ovf: got %b want 0", sb_ovf); else passed++;
  endtask

  task automatic test_write_cc();
    issue_valid = 1; issue_ld_reg = 1; issue_dr = 3'd3;
    advance();
    total++; if (busy !== 8'h08) $display("FAIL wr_busy_set: got %h want 08", busy); else passed++;
    set_idle();
    drive_mem(3'd3, 16'h8000, 1, 1, 0, 0);
    advance();
    set_idle();
    #1;
    total++; if (rf_we !== 1'b1) $display("FAIL wr_rf_we: got %b want 1", rf_we); else passed++;
    total++; if (rf_dr !== 3'd3) $display("FAIL wr_rf_dr: got %0d want 3", rf_dr); else passed++;
    total++; if (rf_data !== 16'h8000) $display("FAIL wr_rf_data: got %h want 8000", rf_data); else passed++;
    advance();
    total++; if (nzp !== 3'b100) $display("FAIL wr_nzp: got %b want 100", nzp); else passed++;
    total++; if (busy[3] !== 1'b0) $display("FAIL wr_busy_clr: got %b want 0", busy[3]); else passed++;
    total++; if (retired !== 16'd1) $display("FAIL wr_retired: got %0d want 1", retired); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL wr_we_drop: got %b want 0", rf_we); else passed++;
  endtask

  task automatic test_ldb();
    drive_mem(3'd1, 16'h80FF, 1, 1, 1, 0);
    advance();
    drive_mem(3'd1, 16'h80FF, 1, 1, 1, 1);
    total++; if (rf_data !== 16'hFFFF) $display("FAIL ldb_lo_neg: got %h want FFFF", rf_data); else passed++;
    advance();
    drive_mem(3'd1, 16'h007F, 1, 1, 1, 0);
    total++; if (rf_data !== 16'hFF80) $display("FAIL ldb_hi_neg: got %h want FF80", rf_data); else passed++;
    advance();
    set_idle();
    #1;
    total++; if (rf_data !== 16'h007F) $display("FAIL ldb_lo_pos: got %h want 007F", rf_data); else passed++;
    advance();
    total++; if (nzp !== 3'b001) $display("FAIL ldb_nzp: got %b want 001", nzp); else passed++;
  endtask

  task automatic test_bypass();
    drive_mem(3'd5, 16'h1234, 1, 0, 0, 0);
    advance();
    set_idle();
    rd_sr1 = 3'd5; rf_sr1_out = 16'h0000; rd_sr2 = 3'd5; rf_sr2_out = 16'h1111;
    #1;
    total++; if (sr1_val !== 16'h1234) $display("FAIL byp_sr1_hit: got %h want 1234", sr1_val); else passed++;
    total++; if (sr2_val !== 16'h1234) $display("FAIL byp_sr2_hit: got %h want 1234", sr2_val); else passed++;
    rd_sr1 = 3'd4; rf_sr1_out = 16'h0ABC;
    #1;
    total++; if (sr1_val !== 16'h0ABC) $display("FAIL byp_sr1_miss: got %h want 0ABC", sr1_val); else passed++;
    advance();
    rd_sr1 = 3'd5; rf_sr1_out = 16'h5555;
    #1;
    total++; if (sr1_val !== 16'h5555) $display("FAIL byp_no_we: got %h want 5555", sr1_val); else passed++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1; issue_ld_reg = 1; issue_dr = 3'd2;
    repeat (3) advance();
    total++; if (busy !== 8'h04) $display("FAIL sb_busy2: got %h want 04", busy); else passed++;
    set_idle();
    drive_mem(3'd2, 16'h0001, 1, 0, 0, 0);
    advance();
    set_idle();
    issue_valid = 1; issue_ld_reg = 1; issue_dr = 3'd2;
    advance();
    total++; if (sb_ovf !== 1'b0) $display("FAIL sb_cancel_ovf: got %b want 0", sb_ovf); else passed++;
    advance();
    total++; if (sb_ovf !== 1'b1) $display("FAIL sb_inc_sat: got %b want 1", sb_ovf); else passed++;
    set_idle();
    for (int k = 0; k < 3; k++) begin
      drive_mem(3'd2, 16'h0002, 1, 0, 0, 0);
      advance();
    end
    total++; if (busy[2] !== 1'b1) $display("FAIL sb_held3: got %b want 1", busy[2]); else passed++;
    set_idle();
    advance();
    total++; if (busy[2] !== 1'b0) $display("FAIL sb_drained: got %b want 0", busy[2]); else passed++;
    total++; if (sb_ovf !== 1'b1) $display("FAIL sb_sticky: got %b want 1", sb_ovf); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1; issue_ld_reg = 1; issue_dr = 3'd6;
    drive_mem(3'd6, 16'h0000, 1, 1, 0, 0);
    advance();
    drive_mem(3'd7, 16'h9000, 1, 1, 0, 0);
    advance();
    total++; if (rf_we !== 1'b1) $display("FAIL mid_pre_we: got %b want 1", rf_we); else passed++;
    rst_n = 0;
    #1;
    model_reset();
    total++; if (rf_we !== 1'b0) $display("FAIL mid_we_async: got %b want 0", rf_we); else passed++;
    total++; if (busy !== 8'h00) $display("FAIL mid_busy: got %h want 00", busy); else passed++;
    total++; if (nzp !== 3'b010) $display("FAIL mid_nzp: got %b want 010", nzp); else passed++;
    total++; if (retired !== 16'd0) $display("FAIL mid_retired: got %0d want 0", retired); else passed++;
    @(negedge clk);
    set_idle();
    rst_n = 1;
    #1;
    advance();
    total++; if (rf_we !== 1'b0) $display("FAIL mid_release_we: got %b want 0", rf_we); else passed++;
    total++; if (retired !== 16'd0) $display("FAIL mid_release_ret: got %0d want 0", retired); else passed++;
  endtask

  task automatic test_random();
    int pend_q[$];
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_idle();
      if ($urandom_range(0, 2) == 0 && pend_q.size() < 6) begin
        issue_valid = 1; issue_ld_reg = 1; issue_dr = 3'($urandom_range(0, 7));
        pend_q.push_back(int'(issue_dr));
      end else if ($urandom_range(0, 3) == 0) begin
        issue_valid = 1; issue_ld_reg = 0; issue_dr = 3'($urandom_range(0, 7));
      end
      if (pend_q.size() > 0 && $urandom_range(0, 1) == 0) begin
        drive_mem(3'(pend_q.pop_front()), 16'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 4) == 0) begin
        drive_mem(3'($urandom_range(0, 7)), 16'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      rd_sr1 = 3'($urandom_range(0, 7)); rd_sr2 = 3'($urandom_range(0, 7));
      rf_sr1_out = 16'($urandom); rf_sr2_out = 16'($urandom);
      #1;
      total++; if (rf_we !== exp_we()) $display("FAIL rnd_we[%0d]: got %b want %b", n, rf_we, exp_we()); else passed++;
      total++; if (rf_dr !== l_dr) $display("FAIL rnd_dr[%0d]: got %0d want %0d", n, rf_dr, l_dr); else passed++;
      total++; if (rf_data !== exp_data()) $display("FAIL rnd_data[%0d]: got %h want %h", n, rf_data, exp_data()); else passed++;
      total++;
      if (sr1_val !== ((exp_we() && rd_sr1 == l_dr) ? exp_data() : rf_sr1_out))
        $display("FAIL rnd_sr1[%0d]: got %h", n, sr1_val);
      else passed++;
      total++;
      if (sr2_val !== ((exp_we() && rd_sr2 == l_dr) ? exp_data() : rf_sr2_out))
        $display("FAIL rnd_sr2[%0d]: got %h", n, sr2_val);
      else passed++;
      total++; if (nzp !== m_nzp) $display("FAIL rnd_nzp[%0d]: got %b want %b", n, nzp, m_nzp); else passed++;
      total++; if (busy !== exp_busy()) $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy, exp_busy()); else passed++;
      total++; if (sb_ovf !== m_ovf) $display("FAIL rnd_ovf[%0d]: got %b want %b", n, sb_ovf, m_ovf); else passed++;
      total++; if (retired !== 16'(m_retired)) $display("FAIL rnd_retired[%0d]: got %0d want %0d", n, retired, m_retired); else passed++;
      advance();
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_write_cc();
    test_ldb();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
